// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-RAM port between the CPU load/store path and an external
// requester, one access per cycle, reads return next cycle. Optional macro DATA_MEM_ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;
  localparam logic [7:0] WAIT_TH  = 8'(MAX_WAIT);
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic [1:0] rd_owner_q, rd_owner_d;
  logic [7:0] ext_wait_q, ext_wait_d;
  logic       ext_force;

  // Without the guard ext_wait is still counted for debug but never overrides CPU priority.
  assign ext_force = GUARD && (ext_wait_q >= WAIT_TH);

  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      ext_gnt = ext_req & (~cpu_req | ext_force);
      cpu_gnt = cpu_req & ~ext_gnt;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign ram_en    = cpu_gnt | ext_gnt;
  assign ram_we    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
  assign ram_addr  = ext_gnt ? ext_addr  : cpu_addr;
  assign ram_wdata = ext_gnt ? ext_wdata : cpu_wdata;

  // Gating with rst drops a read granted just before reset.
  assign cpu_rvalid = (rd_owner_q == OWN_CPU) & ~rst;
  assign ext_rvalid = (rd_owner_q == OWN_EXT) & ~rst;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign ext_rdata  = ext_rvalid ? ram_rdata : '0;

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we)      rd_owner_d = OWN_CPU;
    else if (ext_gnt && !ext_we) rd_owner_d = OWN_EXT;
  end

  always_comb begin
    ext_wait_d = ext_wait_q;
    if (!ext_req || ext_gnt)      ext_wait_d = '0;
    else if (ext_wait_q != 8'hFF) ext_wait_d = ext_wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q <= OWN_NONE;
      ext_wait_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      ext_wait_q <= ext_wait_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: table vectors, directed corner sequences and a randomized run against
// a transaction-level model of the arbiter plus a behavioural RAM.
module tb_data_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MAX_WAIT = 8;
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, ext_req, ext_we;
  logic [AW-1:0] cpu_addr, ext_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata, ram_wdata, ram_rdata, cpu_rdata, ext_rdata;
  logic cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid, ram_en, ram_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM with one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic cr, cw, er, ew;
    logic x_cg, x_eg, x_we, x_stall;
    logic [AW-1:0] x_addr;
  } vec_t;
  vec_t vt [8];

  logic [DW-1:0] ref_mem [8];
  int m_own;
  logic [DW-1:0] m_data;
  int m_wait;
  logic e_cg, e_eg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_cpu_gnt"}, cpu_gnt, 0);
    chk({nm, "_ext_gnt"}, ext_gnt, 0);
    chk({nm, "_ram_en"}, ram_en, 0);
    chk({nm, "_ram_we"}, ram_we, 0);
    chk({nm, "_cpu_rvalid"}, cpu_rvalid, 0);
    chk({nm, "_ext_rvalid"}, ext_rvalid, 0);
    chk({nm, "_cpu_rdata"}, cpu_rdata, 0);
    chk({nm, "_ext_rdata"}, ext_rdata, 0);
    chk({nm, "_rd_owner"}, dut.rd_owner_q, 0);
    chk({nm, "_ext_wait"}, dut.ext_wait_q, 0);
  endtask

  initial begin
    vt[0] = '{0,0,0,0, 0,0,0,0, 13'h000};
    vt[1] = '{1,0,0,0, 1,0,0,0, 13'h111};
    vt[2] = '{1,1,0,0, 1,0,1,0, 13'h111};
    vt[3] = '{0,0,1,0, 0,1,0,0, 13'h222};
    vt[4] = '{0,0,1,1, 0,1,1,0, 13'h222};
    vt[5] = '{1,0,1,1, 1,0,0,0, 13'h111};
    vt[6] = '{1,1,1,0, 1,0,1,0, 13'h111};
    vt[7] = '{1,1,1,1, 1,0,1,0, 13'h111};

    // Reset: grants forced low even with both requesting
    rst = 1'b1; cpu_req = 1'b1; ext_req = 1'b1; cpu_we = 1'b0; ext_we = 1'b1;
    cpu_addr = '0; ext_addr = '0; cpu_wdata = '0; ext_wdata = '0;
    tick(); tick();
    @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_cpu_stall", cpu_stall, 1);
    idle_in();
    tick();
    rst = 1'b0;
    tick();

    // Single-cycle arbitration table
    for (int i = 0; i < 8; i++) begin
      cpu_req = vt[i].cr; cpu_we = vt[i].cw; ext_req = vt[i].er; ext_we = vt[i].ew;
      cpu_addr = 13'h111; ext_addr = 13'h222;
      @(negedge clk);
      chk($sformatf("tbl%0d_cpu_gnt", i), cpu_gnt, vt[i].x_cg);
      chk($sformatf("tbl%0d_ext_gnt", i), ext_gnt, vt[i].x_eg);
      chk($sformatf("tbl%0d_ram_en", i), ram_en, vt[i].x_cg | vt[i].x_eg);
      chk($sformatf("tbl%0d_ram_we", i), ram_we, vt[i].x_we);
      chk($sformatf("tbl%0d_cpu_stall", i), cpu_stall, vt[i].x_stall);
      if (vt[i].x_cg | vt[i].x_eg) chk($sformatf("tbl%0d_ram_addr", i), ram_addr, vt[i].x_addr);
      tick();
      idle_in();
      tick();
    end

    // Preload words 0..7 through the external port
    for (int i = 0; i < 8; i++) begin
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = AW'(i); ext_wdata = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
      @(negedge clk);
      chk("pre_ext_gnt", ext_gnt, 1);
      tick();
    end
    ext_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 13'h010; ext_wdata = 32'hDEAD_BEEF;
    tick();
    idle_in();
    tick();

    // CPU read only
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
    @(negedge clk);
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_stall0", cpu_stall, 0);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", cpu_rvalid, 1);
    chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_stall1", cpu_stall, 0);
    chk("rd_ext_rdata", ext_rdata, 0);
    tick();

    // Contention: CPU write vs ext read of the same word
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h004; cpu_wdata = 32'h1234_5678;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 13'h004;
    ref_mem[4] = 32'h1234_5678;
    @(negedge clk);
    chk("ct0_cpu_gnt", cpu_gnt, 1);
    chk("ct0_ext_gnt", ext_gnt, 0);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ct1_ext_gnt", ext_gnt, 1);
    tick();
    ext_req = 1'b0;
    @(negedge clk);
    chk("ct2_ext_rvalid", ext_rvalid, 1);
    chk("ct2_ext_rdata", ext_rdata, 32'h1234_5678);
    chk("ct2_cpu_rdata", cpu_rdata, 0);
    tick();

    // Back-to-back CPU reads of 0..3
    for (int k = 0; k < 6; k++) begin
      cpu_req = (k < 4); cpu_we = 1'b0; cpu_addr = AW'(k);
      @(negedge clk);
      if (k < 4) chk($sformatf("b2b%0d_gnt", k), cpu_gnt, 1);
      if (k >= 1 && k <= 4) begin
        chk($sformatf("b2b%0d_rvalid", k), cpu_rvalid, 1);
        chk($sformatf("b2b%0d_rdata", k), cpu_rdata, 32'hA000_0000 + k - 1);
      end else begin
        chk($sformatf("b2b%0d_rvalid", k), cpu_rvalid, 0);
      end
      if (k == 5) chk("b2b5_owner", dut.rd_owner_q, 0);
      tick();
    end
    idle_in();

    // Idle
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ram_en", ram_en, 0);
      chk("idle_ram_we", ram_we, 0);
      chk("idle_rvalid", cpu_rvalid | ext_rvalid, 0);
      chk("idle_ext_wait", dut.ext_wait_q, 0);
      tick();
    end

    // Reset in the cycle after an ext read grant
    tick(); tick(); tick();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 13'h001;
    @(negedge clk);
    chk("rmr3_ext_gnt", ext_gnt, 1);
    tick();
    ext_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rmr4_ext_rvalid", ext_rvalid, 0);
    chk("rmr4_ext_rdata", ext_rdata, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rmr5");
    tick();

    // Starvation: both request continuously
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h000;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 13'h001;
    for (int c = 0; c <= 300; c++) begin
      @(negedge clk);
      if (c < 20) begin
        chk($sformatf("stv%0d_ext_gnt", c), ext_gnt, GUARD && (c == 8 || c == 17));
        chk($sformatf("stv%0d_stall", c), cpu_stall, GUARD && (c == 8 || c == 17));
      end
      if (c == 20) chk("stv20_ext_wait", dut.ext_wait_q, GUARD ? 2 : 20);
      if (c == 300 && !GUARD) chk("stv300_ext_wait_sat", dut.ext_wait_q, 255);
      tick();
    end
    idle_in();
    tick(); tick();

    // Randomized run against a transaction-level model
    m_own = 0; m_data = '0; m_wait = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      e_eg = ext_req && (!cpu_req || (GUARD && m_wait >= MAX_WAIT));
      e_cg = cpu_req && !e_eg;
      chk("rnd_cpu_gnt", cpu_gnt, e_cg);
      chk("rnd_ext_gnt", ext_gnt, e_eg);
      chk("rnd_ram_en", ram_en, e_cg | e_eg);
      chk("rnd_cpu_stall", cpu_stall, cpu_req && !e_cg);
      chk("rnd_cpu_rvalid", cpu_rvalid, m_own == 1);
      chk("rnd_ext_rvalid", ext_rvalid, m_own == 2);
      chk("rnd_cpu_rdata", cpu_rdata, (m_own == 1) ? m_data : '0);
      chk("rnd_ext_rdata", ext_rdata, (m_own == 2) ? m_data : '0);
      if (e_cg) chk("rnd_ram_addr_c", ram_addr, cpu_addr);
      if (e_eg) chk("rnd_ram_addr_e", ram_addr, ext_addr);
      m_own = 0;
      if (e_cg) begin
        if (cpu_we) ref_mem[cpu_addr[2:0]] = cpu_wdata;
        else begin m_own = 1; m_data = ref_mem[cpu_addr[2:0]]; end
      end
      if (e_eg) begin
        if (ext_we) ref_mem[ext_addr[2:0]] = ext_wdata;
        else begin m_own = 2; m_data = ref_mem[ext_addr[2:0]]; end
      end
      if (!ext_req || e_eg) m_wait = 0;
      else if (m_wait < 255) m_wait++;
      tick();
      if (!cpu_req || e_cg) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = $urandom_range(0, 1);
        cpu_addr = AW'($urandom_range(0, 7));
        cpu_wdata = $urandom;
      end
      if (!ext_req || e_eg) begin
        ext_req = ($urandom_range(0, 2) != 0);
        ext_we = $urandom_range(0, 1);
        ext_addr = AW'($urandom_range(0, 7));
        ext_wdata = $urandom;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
